// File: rtl/fetch_ifid_stage.sv
// ---------------------------------------------------------------------------
// fetch_ifid_stage
//   Instruction-fetch stage and IF/ID pipeline register for a 5-stage
//   LEGv8-style pipeline. Owns the PC, drives the instruction-memory address,
//   latches the fetched word and its PC into IF/ID, and decodes the register
//   index fields used by the load-use hazard detector. Honors the hazard
//   detector's write enables, applies branch redirect/flush, and counts
//   stall cycles (saturating) for performance debug.
//
// Ports
//   clk            in   clock, all state updates on rising edge
//   reset          in   synchronous active-high reset
//   PC_WriteEn     in   1 = PC may advance, 0 = hold PC
//   IFID_WriteEn   in   1 = IF/ID may load, 0 = hold IF/ID
//   Branch_taken   in   redirect PC to Branch_target and flush IF/ID
//   Branch_target  in   redirect address (low two bits ignored)
//   IMem_addr      out  instruction-memory address (copy of PC)
//   IMem_data      in   instruction word at IMem_addr, same cycle
//   IFID_pc        out  PC of the instruction held in IF/ID
//   IFID_instr     out  instruction held in IF/ID
//   IFID_valid     out  1 = real instruction, 0 = bubble
//   IFID_rn        out  instr[9:5]   when valid, else 31
//   IFID_rm        out  instr[20:16] when valid, else 31
//   IFID_rd        out  instr[4:0]   when valid, else 31
//   Stall_count    out  cycles with PC_WriteEn=0 since reset, saturating
// ---------------------------------------------------------------------------
module fetch_ifid_stage #(
    parameter int unsigned              ADDR_WIDTH  = 64,
    parameter int unsigned              INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]    RESET_PC    = '0,
    parameter int unsigned              CNT_WIDTH   = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    PC_WriteEn,
    input  logic                    IFID_WriteEn,
    input  logic                    Branch_taken,
    input  logic [ADDR_WIDTH-1:0]   Branch_target,
    output logic [ADDR_WIDTH-1:0]   IMem_addr,
    input  logic [INSTR_WIDTH-1:0]  IMem_data,
    output logic [ADDR_WIDTH-1:0]   IFID_pc,
    output logic [INSTR_WIDTH-1:0]  IFID_instr,
    output logic                    IFID_valid,
    output logic [4:0]              IFID_rn,
    output logic [4:0]              IFID_rm,
    output logic [4:0]              IFID_rd,
    output logic [CNT_WIDTH-1:0]    Stall_count
);

    localparam int unsigned REG_W   = 5;
    localparam int unsigned RD_LSB  = 0;
    localparam int unsigned RN_LSB  = 5;
    localparam int unsigned RM_LSB  = 16;
    localparam logic [REG_W-1:0]      XZR      = REG_W'(31);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MK = ~ADDR_WIDTH'(3);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = '1;

    logic [ADDR_WIDTH-1:0]  pc_q,        pc_d;
    logic [ADDR_WIDTH-1:0]  ifid_pc_q,   ifid_pc_d;
    logic [INSTR_WIDTH-1:0] ifid_instr_q, ifid_instr_d;
    logic                   ifid_valid_q, ifid_valid_d;
    logic [CNT_WIDTH-1:0]   stall_cnt_q, stall_cnt_d;

    // Next-state: branch redirect/flush beats the enables; enables act independently.
    always_comb begin
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        stall_cnt_d  = stall_cnt_q;

        if (Branch_taken) begin
            // Word-align the redirect target.
            pc_d         = Branch_target & ALIGN_MK;
            ifid_pc_d    = '0;
            ifid_instr_d = '0;
            ifid_valid_d = 1'b0;
        end else begin
            if (PC_WriteEn) begin
                pc_d = pc_q + PC_STEP;
            end
            if (IFID_WriteEn) begin
                ifid_pc_d    = pc_q;
                ifid_instr_d = IMem_data;
                ifid_valid_d = 1'b1;
            end
        end

        // Counts every PC-hold edge, branch or not; sticks at all-ones.
        if (!PC_WriteEn && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            ifid_pc_q    <= '0;
            ifid_instr_q <= '0;
            ifid_valid_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign IMem_addr   = pc_q;
    assign IFID_pc     = ifid_pc_q;
    assign IFID_instr  = ifid_instr_q;
    assign IFID_valid  = ifid_valid_q;
    assign Stall_count = stall_cnt_q;

    // Bubbles report XZR so the hazard detector never matches against them.
    assign IFID_rn = ifid_valid_q ? ifid_instr_q[RN_LSB +: REG_W] : XZR;
    assign IFID_rm = ifid_valid_q ? ifid_instr_q[RM_LSB +: REG_W] : XZR;
    assign IFID_rd = ifid_valid_q ? ifid_instr_q[RD_LSB +: REG_W] : XZR;

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_ifid_stage
//   Directed bench for fetch_ifid_stage. Two instances share the clock:
//   dut_a uses default parameters, dut_b uses RESET_PC = 2^64-4 and a 4-bit
//   stall counter. Stimulus pushes hand-computed expected snapshots into a
//   queue; a monitor pops one per falling edge and compares all outputs.
// ---------------------------------------------------------------------------
module tb_fetch_ifid_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A signals
    logic        a_reset, a_pwe, a_iwe, a_bt;
    logic [63:0] a_tgt, a_addr, a_ifid_pc;
    logic [31:0] a_data, a_instr, a_cnt;
    logic        a_valid;
    logic [4:0]  a_rn, a_rm, a_rd;

    // Instance B signals
    logic        b_reset, b_pwe, b_iwe, b_bt;
    logic [63:0] b_tgt, b_addr, b_ifid_pc;
    logic [31:0] b_data, b_instr;
    logic [3:0]  b_cnt;
    logic        b_valid;
    logic [4:0]  b_rn, b_rm, b_rd;

    // Instruction memory contents; unlisted addresses return {CAFE, addr[15:0]}.
    function automatic logic [31:0] imem(input logic [63:0] a);
        case (a)
            64'd0:   imem = 32'h8B02_0020;
            64'd4:   imem = 32'h8B03_0041;
            64'd8:   imem = 32'hF840_8062;
            default: imem = {16'hCAFE, a[15:0]};
        endcase
    endfunction

    assign a_data = imem(a_addr);
    assign b_data = imem(b_addr);

    fetch_ifid_stage dut_a (
        .clk(clk), .reset(a_reset), .PC_WriteEn(a_pwe), .IFID_WriteEn(a_iwe),
        .Branch_taken(a_bt), .Branch_target(a_tgt), .IMem_addr(a_addr),
        .IMem_data(a_data), .IFID_pc(a_ifid_pc), .IFID_instr(a_instr),
        .IFID_valid(a_valid), .IFID_rn(a_rn), .IFID_rm(a_rm), .IFID_rd(a_rd),
        .Stall_count(a_cnt)
    );

    fetch_ifid_stage #(
        .ADDR_WIDTH(64), .INSTR_WIDTH(32),
        .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .CNT_WIDTH(4)
    ) dut_b (
        .clk(clk), .reset(b_reset), .PC_WriteEn(b_pwe), .IFID_WriteEn(b_iwe),
        .Branch_taken(b_bt), .Branch_target(b_tgt), .IMem_addr(b_addr),
        .IMem_data(b_data), .IFID_pc(b_ifid_pc), .IFID_instr(b_instr),
        .IFID_valid(b_valid), .IFID_rn(b_rn), .IFID_rm(b_rm), .IFID_rd(b_rd),
        .Stall_count(b_cnt)
    );

    typedef struct {
        int          tag;
        logic        sel;
        logic [63:0] addr;
        logic [63:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic [4:0]  rn, rm, rd;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input int tag, input string nm,
                       input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL step=%0d %s actual=%0h required=%0h", tag, nm, act, exp);
        end
    endtask

    task automatic push(input int tag, input logic sel, input logic [63:0] addr,
                        input logic [63:0] pc, input logic [31:0] instr,
                        input logic valid, input logic [4:0] rn, input logic [4:0] rm,
                        input logic [4:0] rd, input logic [31:0] cnt);
        exp_t e;
        e.tag = tag; e.sel = sel; e.addr = addr; e.pc = pc; e.instr = instr;
        e.valid = valid; e.rn = rn; e.rm = rm; e.rd = rd; e.cnt = cnt;
        sb.push_back(e);
    endtask

    task automatic step_a(input logic rst, input logic pwe, input logic iwe,
                          input logic bt, input logic [63:0] tgt);
        @(negedge clk);
        a_reset = rst; a_pwe = pwe; a_iwe = iwe; a_bt = bt; a_tgt = tgt;
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic rst, input logic pwe, input logic iwe,
                          input logic bt, input logic [63:0] tgt);
        @(negedge clk);
        b_reset = rst; b_pwe = pwe; b_iwe = iwe; b_bt = bt; b_tgt = tgt;
        @(posedge clk);
        #1;
    endtask

    // Monitor: one expected snapshot per falling edge, compared against all outputs.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            e_mon = sb.pop_front();
            if (!e_mon.sel) begin
                chk(e_mon.tag, "a.IMem_addr",   a_addr,          e_mon.addr);
                chk(e_mon.tag, "a.IFID_pc",     a_ifid_pc,       e_mon.pc);
                chk(e_mon.tag, "a.IFID_instr",  64'(a_instr),    64'(e_mon.instr));
                chk(e_mon.tag, "a.IFID_valid",  64'(a_valid),    64'(e_mon.valid));
                chk(e_mon.tag, "a.IFID_rn",     64'(a_rn),       64'(e_mon.rn));
                chk(e_mon.tag, "a.IFID_rm",     64'(a_rm),       64'(e_mon.rm));
                chk(e_mon.tag, "a.IFID_rd",     64'(a_rd),       64'(e_mon.rd));
                chk(e_mon.tag, "a.Stall_count", 64'(a_cnt),      64'(e_mon.cnt));
            end else begin
                chk(e_mon.tag, "b.IMem_addr",   b_addr,          e_mon.addr);
                chk(e_mon.tag, "b.IFID_pc",     b_ifid_pc,       e_mon.pc);
                chk(e_mon.tag, "b.IFID_instr",  64'(b_instr),    64'(e_mon.instr));
                chk(e_mon.tag, "b.IFID_valid",  64'(b_valid),    64'(e_mon.valid));
                chk(e_mon.tag, "b.IFID_rn",     64'(b_rn),       64'(e_mon.rn));
                chk(e_mon.tag, "b.IFID_rm",     64'(b_rm),       64'(e_mon.rm));
                chk(e_mon.tag, "b.IFID_rd",     64'(b_rd),       64'(e_mon.rd));
                chk(e_mon.tag, "b.Stall_count", 64'(b_cnt),      64'(e_mon.cnt));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        a_reset = 1'b1; a_pwe = 1'b1; a_iwe = 1'b1; a_bt = 1'b0; a_tgt = '0;
        b_reset = 1'b1; b_pwe = 1'b1; b_iwe = 1'b1; b_bt = 1'b0; b_tgt = '0;

        // ---------------- Instance A (RESET_PC = 0) ----------------
        step_a(1, 1, 1, 0, 64'd0);
        push(0,  0, 64'd0, 64'd0, 32'h0, 0, 31, 31, 31, 0);
        step_a(0, 1, 1, 0, 64'd0);
        push(1,  0, 64'd4, 64'd0, 32'h8B02_0020, 1, 1, 2, 0, 0);
        step_a(0, 1, 1, 0, 64'd0);
        push(2,  0, 64'd8, 64'd4, 32'h8B03_0041, 1, 2, 3, 1, 0);
        // Load-use stall at PC=8
        step_a(0, 0, 0, 0, 64'd0);
        push(3,  0, 64'd8, 64'd4, 32'h8B03_0041, 1, 2, 3, 1, 1);
        step_a(0, 1, 1, 0, 64'd0);
        push(4,  0, 64'd12, 64'd8, 32'hF840_8062, 1, 3, 0, 2, 1);
        // Enables split: PC held, IF/ID loads
        step_a(0, 0, 1, 0, 64'd0);
        push(5,  0, 64'd12, 64'd12, 32'hCAFE_000C, 1, 0, 30, 12, 2);
        // Enables split: PC advances, IF/ID holds
        step_a(0, 1, 0, 0, 64'd0);
        push(6,  0, 64'd16, 64'd12, 32'hCAFE_000C, 1, 0, 30, 12, 2);
        // Branch during stall, unaligned target
        step_a(0, 0, 0, 1, 64'h103);
        push(7,  0, 64'h100, 64'd0, 32'h0, 0, 31, 31, 31, 3);
        step_a(0, 1, 1, 0, 64'd0);
        push(8,  0, 64'h104, 64'h100, 32'hCAFE_0100, 1, 8, 30, 0, 3);
        // Branch with enables high to the top aligned address
        step_a(0, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF);
        push(9,  0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 32'h0, 0, 31, 31, 31, 3);
        // PC wraps to 0
        step_a(0, 1, 1, 0, 64'd0);
        push(10, 0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 32'hCAFE_FFFC, 1, 31, 30, 28, 3);
        // Reset mid-stall with a branch pending: both discarded
        step_a(1, 0, 0, 1, 64'h500);
        push(11, 0, 64'd0, 64'd0, 32'h0, 0, 31, 31, 31, 0);
        step_a(0, 1, 1, 0, 64'd0);
        push(12, 0, 64'd4, 64'd0, 32'h8B02_0020, 1, 1, 2, 0, 0);

        // ---------------- Instance B (RESET_PC = 2^64-4, 4-bit counter) ----------------
        step_b(1, 1, 1, 0, 64'd0);
        push(20, 1, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 32'h0, 0, 31, 31, 31, 0);
        step_b(0, 1, 1, 0, 64'd0);
        push(21, 1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 32'hCAFE_FFFC, 1, 31, 30, 28, 0);
        // 20 stall cycles: counter saturates at 15
        for (int i = 1; i <= 20; i++) begin
            step_b(0, 0, 0, 0, 64'd0);
            push(21 + i, 1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 32'hCAFE_FFFC, 1, 31, 30, 28,
                 (i > 15) ? 32'd15 : 32'(i));
        end
        // Branch while saturated: redirect happens, counter stays at 15
        step_b(0, 0, 0, 1, 64'h0000_0000_0000_2006);
        push(42, 1, 64'h2004, 64'd0, 32'h0, 0, 31, 31, 31, 15);

        repeat (3) @(negedge clk);
        #1;
        chk(99, "scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_ifid_stage.md
Name: fetch_ifid_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register for the 5-stage LEGv8-style pipeline. Holds the PC and drives the instruction-memory address. Latches the fetched word and PC into IF/ID and decodes the register-index fields (rn, rm, rd) consumed by the load-use hazard detector. Obeys that detector's PC/IF-ID write enables, applies branch redirect/flush from the branch-resolution stage, and keeps a saturating stall-cycle counter for performance debug.

Parameters:
ADDR_WIDTH, 64, PC and instruction-address width in bits
INSTR_WIDTH, 32, instruction word width
RESET_PC, 0, PC value loaded on reset
CNT_WIDTH, 32, stall counter width

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous active-high reset
PC_WriteEn  input  1  1 = PC may advance; 0 = hold PC (from hazard detector)
IFID_WriteEn  input  1  1 = IF/ID may load; 0 = hold IF/ID (from hazard detector)
Branch_taken  input  1  branch resolved taken this cycle; redirect and flush
Branch_target  input  ADDR_WIDTH  redirect address, valid when Branch_taken=1
IMem_addr  output  ADDR_WIDTH  instruction-memory address; combinational copy of PC
IMem_data  input  INSTR_WIDTH  instruction word at IMem_addr, same cycle (async read)
IFID_pc  output  ADDR_WIDTH  PC of the instruction held in IF/ID
IFID_instr  output  INSTR_WIDTH  instruction held in IF/ID
IFID_valid  output  1  1 = IF/ID holds a real instruction; 0 = bubble
IFID_rn  output  5  instr[9:5] when valid, else 5'd31
IFID_rm  output  5  instr[20:16] when valid, else 5'd31
IFID_rd  output  5  instr[4:0] when valid, else 5'd31
Stall_count  output  CNT_WIDTH  number of cycles with PC_WriteEn=0 since reset, saturating

Behaviour:
- Registers: PC, IFID_pc, IFID_instr, IFID_valid, Stall_count. All other outputs are combinational from these.
- Reset (reset=1 at edge, overrides all other inputs): PC<=RESET_PC; IFID_pc<=0; IFID_instr<=0; IFID_valid<=0; Stall_count<=0. So after reset: IMem_addr=RESET_PC, IFID_rn/rm/rd=31. Reset in the middle of a stall or branch discards that stall or branch entirely.
- Per-edge priority, highest first: reset > Branch_taken > stall (enables low) > normal advance.
- Branch_taken=1: PC<={Branch_target[ADDR_WIDTH-1:2],2'b00}, with the low two bits forced to 0. IF/ID is flushed: IFID_valid<=0, IFID_instr<=0, IFID_pc<=0. PC_WriteEn and IFID_WriteEn are ignored for this edge.
- No branch, PC_WriteEn=0: PC holds.
- No branch, IFID_WriteEn=0: IF/ID holds all three fields.
- The two enables act independently. The hazard detector drives them equal, but the block does not rely on that.
- No branch, PC_WriteEn=1: PC<=PC+4, wrapping modulo 2^ADDR_WIDTH (all-ones-minus-3 advances to 0).
- No branch, IFID_WriteEn=1: IFID_pc<=PC; IFID_instr<=IMem_data; IFID_valid<=1.
- Fetch latency: the instruction at address A appears in IF/ID exactly one edge after PC==A with IFID_WriteEn=1.
- Field decode: when IFID_valid=0, rn/rm/rd are forced to 31 (XZR) to suppress false load-use matches against a bubble.
- Stall_count: increments by 1 on every non-reset edge where PC_WriteEn=0, including edges where Branch_taken=1. Holds at all-ones; no wrap.
- No X propagation: every register has a defined reset value. Outputs must be fully defined one edge after reset.

Test Plan:
- Reset then free-run, RESET_PC=0, enables=1, IMem_data=0x8B020020 at addr 0, 0x8B030041 at addr 4 -> cycle 1: IFID_pc=0, IFID_instr=0x8B020020, rn=1, rm=2, rd=0, valid=1. Cycle 2: IFID_pc=4. IMem_addr steps 0,4,8.
- Load-use stall: at PC=8 drop both enables for 1 cycle -> PC stays 8 and IF/ID unchanged for that edge. Next enabled edge resumes with PC=12. Stall_count=1.
- Branch during stall: PC_WriteEn=IFID_WriteEn=0, Branch_taken=1, Branch_target=0x103 -> PC=0x100, IFID_valid=0, rn=rm=rd=31. Stall_count increments.
- Wrap-around: with RESET_PC=2^64-4, advance one edge -> IMem_addr=0, IFID_pc=2^64-4.
- Reset mid-stall: enables=0 and reset=1 on the same edge -> PC=RESET_PC, valid=0, Stall_count=0.
- Counter saturation: CNT_WIDTH=4, hold PC_WriteEn=0 for 20 cycles -> Stall_count stops at 15.
